// File: rtl/run_ctrl.sv
// Run/stop/step controller for the three-phase clock generator.
// Keeps a mirror of the generator's phase so that halt only changes on machine-cycle boundaries.
module run_ctrl #(
  parameter int unsigned STEP_CYCLES   = 1,
  parameter int unsigned CNT_W         = 32,
  parameter bit          START_RUNNING = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             step_req,
  input  logic             hlt_instr,
  output logic             halt,
  output logic             running,
  output logic             halted_by_instr,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [2:0]       phase_r;
  logic [7:0]       step_left_r;
  logic [7:0]       step_left_nx_s;
  logic             hbi_r;
  logic             hbi_nx_s;
  logic             halt_r;
  logic             running_r;
  logic [CNT_W-1:0] count_r;
  logic             run_pend_r;
  logic             stop_pend_r;
  logic             step_pend_r;
  logic             boundary_s;
  logic             run_s;
  logic             stop_s;
  logic             step_s;
  logic             hlt_q_s;

  // Requests seen on the boundary edge itself act together with anything latched earlier.
  assign boundary_s = phase_r[2];
  assign run_s      = run_pend_r  | run_req;
  assign stop_s     = stop_pend_r | stop_req;
  assign step_s     = step_pend_r | step_req;
  assign hlt_q_s    = boundary_s & ~halt_r & hlt_instr;

  // Next state assuming the current edge is a boundary edge; priority stop > hlt_q > step > run.
  always_comb begin
    state_nx_s     = state_r;
    step_left_nx_s = step_left_r;
    hbi_nx_s       = hbi_r;
    case (state_r)
      ST_RUN: begin
        if (stop_s) begin
          state_nx_s = ST_HALTED;
        end else if (hlt_q_s) begin
          state_nx_s = ST_HALTED;
          hbi_nx_s   = 1'b1;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (stop_s) begin
          state_nx_s     = ST_HALTED;
          step_left_nx_s = 8'd0;
        end else if (hlt_q_s) begin
          state_nx_s     = ST_HALTED;
          hbi_nx_s       = 1'b1;
          step_left_nx_s = 8'd0;
        end else if (run_s) begin
          state_nx_s     = ST_RUN;
          step_left_nx_s = 8'd0;
        end else if (step_left_r <= 8'd1) begin
          state_nx_s     = ST_HALTED;
          step_left_nx_s = 8'd0;
        end else begin
          step_left_nx_s = step_left_r - 8'd1;
        end
      end
      ST_HALTED: begin
        if (stop_s) begin
          state_nx_s = ST_HALTED;
        end else if (step_s) begin
          state_nx_s     = ST_STEP;
          step_left_nx_s = 8'(STEP_CYCLES);
          hbi_nx_s       = 1'b0;
        end else if (run_s) begin
          state_nx_s = ST_RUN;
          hbi_nx_s   = 1'b0;
        end else begin
          state_nx_s = ST_HALTED;
        end
      end
      default: begin
        state_nx_s     = ST_HALTED;
        step_left_nx_s = 8'd0;
      end
    endcase
  end

  // Phase mirror, request latching and boundary-only state/output updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r     <= 3'b001;
      state_r     <= START_RUNNING ? ST_RUN : ST_HALTED;
      halt_r      <= ~START_RUNNING;
      running_r   <= START_RUNNING;
      hbi_r       <= 1'b0;
      step_left_r <= 8'd0;
      count_r     <= '0;
      run_pend_r  <= 1'b0;
      stop_pend_r <= 1'b0;
      step_pend_r <= 1'b0;
    end else begin
      phase_r <= {phase_r[1:0], phase_r[2]};
      if (boundary_s) begin
        state_r     <= state_nx_s;
        halt_r      <= (state_nx_s == ST_HALTED);
        running_r   <= (state_nx_s != ST_HALTED);
        hbi_r       <= hbi_nx_s;
        step_left_r <= step_left_nx_s;
        run_pend_r  <= 1'b0;
        stop_pend_r <= 1'b0;
        step_pend_r <= 1'b0;
        if (!halt_r) begin
          count_r <= count_r + CNT_W'(1);
        end else begin
          count_r <= count_r;
        end
      end else begin
        run_pend_r  <= run_pend_r  | run_req;
        stop_pend_r <= stop_pend_r | stop_req;
        step_pend_r <= step_pend_r | step_req;
      end
    end
  end

  assign halt            = halt_r;
  assign running         = running_r;
  assign halted_by_instr = hbi_r;
  assign cycle_count     = count_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: STEP_CYCLES=3, CNT_W=4, plus a START_RUNNING=0 instance for reset state.
module tb_run_ctrl;

  logic       clk;
  logic       reset;
  logic       run_req;
  logic       stop_req;
  logic       step_req;
  logic       hlt_instr;
  logic       halt;
  logic       running;
  logic       halted_by_instr;
  logic [3:0] cycle_count;
  logic       h_halt;
  logic       h_running;
  logic       h_hbi;
  logic [3:0] h_count;

  int checks = 0;
  int errors = 0;
  int ph     = 0;

  run_ctrl #(.STEP_CYCLES(3), .CNT_W(4), .START_RUNNING(1'b1)) u_dut (
    .clk(clk), .reset(reset), .run_req(run_req), .stop_req(stop_req),
    .step_req(step_req), .hlt_instr(hlt_instr), .halt(halt), .running(running),
    .halted_by_instr(halted_by_instr), .cycle_count(cycle_count)
  );

  run_ctrl #(.STEP_CYCLES(3), .CNT_W(4), .START_RUNNING(1'b0)) u_dut_h (
    .clk(clk), .reset(reset), .run_req(run_req), .stop_req(stop_req),
    .step_req(step_req), .hlt_instr(hlt_instr), .halt(h_halt), .running(h_running),
    .halted_by_instr(h_hbi), .cycle_count(h_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ph tracks which phase the DUT is in during the cycle after the edge just passed
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph == 2) ? 0 : ph + 1;
  endtask

  task automatic to_ph(input int p);
    while (ph != p) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ph = 0;
  endtask

  initial begin
    reset = 1'b0; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0; hlt_instr = 1'b0;
    #2;
    do_reset();
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd1);
    check("rst_hbi", {31'd0, halted_by_instr}, 32'd0);
    check("rst_count", {28'd0, cycle_count}, 32'd0);
    check("rst_h_halt", {31'd0, h_halt}, 32'd1);
    check("rst_h_running", {31'd0, h_running}, 32'd0);
    check("rst_h_count", {28'd0, h_count}, 32'd0);

    // free run for 12 clocks: four boundaries
    for (int i = 0; i < 12; i++) begin
      tick();
      check("run_halt", {31'd0, halt}, 32'd0);
      if (i == 2) check("run_count1", {28'd0, cycle_count}, 32'd1);
    end
    check("run_count4", {28'd0, cycle_count}, 32'd4);

    // stop in phase 010 of cycle 2
    do_reset();
    tick(); tick(); tick();
    tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    check("stop_pre_halt", {31'd0, halt}, 32'd0);
    tick();
    check("stop_halt", {31'd0, halt}, 32'd1);
    check("stop_running", {31'd0, running}, 32'd0);
    check("stop_count", {28'd0, cycle_count}, 32'd2);
    for (int i = 0; i < 6; i++) tick();
    check("stop_frozen", {28'd0, cycle_count}, 32'd2);
    check("stop_still_halt", {31'd0, halt}, 32'd1);

    // single step request runs exactly 3 machine cycles
    to_ph(1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("step_halt_low", {31'd0, halt}, 32'd0);
      check("step_running", {31'd0, running}, 32'd1);
      step_req = (i == 3);
      tick();
      step_req = 1'b0;
    end
    check("step_done_halt", {31'd0, halt}, 32'd1);
    check("step_count", {28'd0, cycle_count}, 32'd5);
    tick(); tick(); tick();
    check("step_no_extra", {31'd0, halt}, 32'd1);

    // run, then hlt_instr outside phase 100 has no effect
    run_req = 1'b1; tick(); run_req = 1'b0;
    to_ph(0);
    check("run_resume", {31'd0, halt}, 32'd0);
    hlt_instr = 1'b1; tick(); tick(); hlt_instr = 1'b0;
    tick();
    check("hlt_ignored_halt", {31'd0, halt}, 32'd0);
    check("hlt_ignored_hbi", {31'd0, halted_by_instr}, 32'd0);
    check("hlt_ignored_count", {28'd0, cycle_count}, 32'd6);
    to_ph(2);
    hlt_instr = 1'b1; tick(); hlt_instr = 1'b0;
    check("hlt_halt", {31'd0, halt}, 32'd1);
    check("hlt_hbi", {31'd0, halted_by_instr}, 32'd1);
    check("hlt_count", {28'd0, cycle_count}, 32'd7);
    to_ph(1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    tick();
    check("rerun_halt", {31'd0, halt}, 32'd0);
    check("rerun_hbi", {31'd0, halted_by_instr}, 32'd0);

    // stop+step on the boundary while halted
    to_ph(1);
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    tick();
    check("halt_again", {31'd0, halt}, 32'd1);
    check("halt_again_count", {28'd0, cycle_count}, 32'd8);
    to_ph(2);
    stop_req = 1'b1; step_req = 1'b1; tick(); stop_req = 1'b0; step_req = 1'b0;
    check("stopstep_halt", {31'd0, halt}, 32'd1);
    tick(); tick(); tick();
    check("stopstep_stay", {31'd0, halt}, 32'd1);
    check("stopstep_count", {28'd0, cycle_count}, 32'd8);

    // run+stop on the boundary while running
    to_ph(1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    tick();
    check("run2_halt", {31'd0, halt}, 32'd0);
    to_ph(2);
    run_req = 1'b1; stop_req = 1'b1; tick(); run_req = 1'b0; stop_req = 1'b0;
    check("runstop_halt", {31'd0, halt}, 32'd1);
    check("runstop_count", {28'd0, cycle_count}, 32'd9);

    // reset in the middle of a step
    to_ph(1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    tick(); tick(); tick();
    check("midstep_count", {28'd0, cycle_count}, 32'd10);
    check("midstep_halt", {31'd0, halt}, 32'd0);
    tick();
    do_reset();
    check("midrst_halt", {31'd0, halt}, 32'd0);
    check("midrst_running", {31'd0, running}, 32'd1);
    check("midrst_count", {28'd0, cycle_count}, 32'd0);
    check("midrst_h_halt", {31'd0, h_halt}, 32'd1);
    for (int i = 0; i < 9; i++) tick();
    check("midrst_free_run", {31'd0, halt}, 32'd0);
    check("midrst_count3", {28'd0, cycle_count}, 32'd3);

    // counter wrap with CNT_W=4
    for (int i = 0; i < 36; i++) tick();
    check("wrap_max", {28'd0, cycle_count}, 32'd15);
    tick(); tick(); tick();
    check("wrap_zero", {28'd0, cycle_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Drives the `halt` input of the three-phase clock generator, which produces the one-hot cycle, memory and internal phases.
- Mirrors the generator's phase counter, so `halt` only changes on machine-cycle boundaries. A 3-phase machine cycle is never truncated.
- Implements run, stop, single/multi-step and CPU HLT instruction handling.
- Counts completed machine cycles for debug.

Parameters:
- STEP_CYCLES, 1, machine cycles executed per step request (1..255).
- CNT_W, 32, width of cycle_count.
- START_RUNNING, 1, 1: leave reset in RUN; 0: leave reset in HALTED.

Ports:
- clk  in  1  system clock; same clock as the phase generator.
- reset  in  1  synchronous, active-high reset.
- run_req  in  1  pulse: enter continuous run.
- stop_req  in  1  pulse: halt at the next boundary.
- step_req  in  1  pulse: execute STEP_CYCLES machine cycles, then halt.
- hlt_instr  in  1  CPU decoded HLT; qualified only during the internal phase.
- halt  out  1  to the phase generator; 1 masks all phase outputs.
- running  out  1  state is RUN or STEP.
- halted_by_instr  out  1  last halt was caused by hlt_instr.
- cycle_count  out  CNT_W  completed machine cycles, wraps.

Behaviour:
- Phase mirror
  - 3-bit one-hot phase, reset value 001.
  - Sequence 001 -> 010 -> 100 -> 001 every clk, independent of halt.
  - Boundary edge = clk edge where phase==100.
  - All state, halt and cycle_count updates happen only on boundary edges. New values are visible from the following phase-001 cycle.
- Reset values
  - With START_RUNNING=1: state RUN, halt=0, running=1.
  - With START_RUNNING=0: state HALTED, halt=1, running=0.
  - halted_by_instr=0, cycle_count=0, step_left=0, pending flags cleared.
  - Reset mid-cycle or mid-step aborts immediately; the phase mirror restarts at 001.
- Request latching
  - run_req, stop_req and step_req set sticky pending flags on any non-boundary edge.
  - Pending flags are consumed and cleared on the next boundary edge.
  - A request arriving on the boundary edge itself is acted on at that edge.
- hlt_instr qualification
  - hlt_instr is qualified (hlt_q) only when phase==100 and halt==0, i.e. on the boundary edge.
  - Otherwise it is ignored.
- Cycle counting
  - On every boundary edge with halt==0: cycle_count += 1, modulo 2^CNT_W.
- States: HALTED, RUN, STEP. Boundary-edge transitions, priority stop > hlt_q > step > run.
  - RUN
    - stop: -> HALTED, halt=1.
    - hlt_q: -> HALTED, halt=1, halted_by_instr=1.
    - step, run: discarded, stay RUN.
  - STEP (step_left > 0)
    - stop: -> HALTED, step_left=0.
    - hlt_q: -> HALTED, halted_by_instr=1, step_left=0.
    - Otherwise step_left -= 1. If the new value is 0: -> HALTED, halt=1.
    - run: -> RUN, step_left=0.
    - step: discarded.
  - HALTED
    - step: -> STEP, halt=0, step_left=STEP_CYCLES, halted_by_instr=0.
    - run: -> RUN, halt=0, halted_by_instr=0.
    - stop: discarded.
- Derived outputs
  - running = (state != HALTED).
  - halt = (state == HALTED).
  - Both are registered; no combinational path from any request to halt.
- Simultaneous requests: only the highest-priority pending request acts; all pending flags clear on that boundary.

Test Plan:
- Reset with START_RUNNING=1, no requests for 12 clks -> halt=0 throughout; cycle_count=4 after the 4th boundary edge; phase mirror 001 at the first post-reset clk.
- stop_req pulsed in the phase-010 cycle of cycle 2 -> halt rises exactly at the next phase-001 cycle; cycle_count freezes at 2; running=0.
- From HALTED with STEP_CYCLES=3, step_req pulsed once -> halt=0 for exactly 9 clks (3 full cycles), then halt=1; cycle_count +3; extra step_req during STEP is ignored.
- RUN, hlt_instr held high during phases 001/010 only -> no effect. hlt_instr high at phase 100 -> halt=1 next cycle, halted_by_instr=1; subsequent run_req clears it and resumes.
- stop_req and step_req on the same boundary edge while HALTED -> stays HALTED. run_req and stop_req on the same boundary edge while RUN -> HALTED.
- Reset asserted mid-step (step_left=2) -> next clk: state per START_RUNNING, cycle_count=0, step_left=0. Preload cycle_count to 2^CNT_W-1 via a small-CNT_W build (CNT_W=4) -> wraps to 0.
